button_conditioner: RTL

- Front end for the board push-buttons. Converts raw asynchronous, bouncing, active-low button pins into clean, synchronous, active-high levels and one-cycle press/release event pulses.
- Sits between the button pins and the control FSMs, which then compare against clean one-hot patterns instead of raw ~button samples.
- One independent conditioning channel per button.

---
 rtl/button_conditioner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// ============================================================================
//  Module   : button_conditioner
//  Brief    : Synchronizes, debounces and edge-detects raw push-button pins.
//             Define AUTOREPEAT_EN to add hold-to-repeat pulses per channel.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic [N_BUTTONS-1:0] btn_repeat
);

    localparam int                 CNT_W            = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   c_CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BUTTONS-1:0] c_RELEASED_PINS =
        (ACTIVE_LOW != 0) ? {N_BUTTONS{1'b1}} : {N_BUTTONS{1'b0}};

    logic [N_BUTTONS-1:0] r_sync1;
    logic [N_BUTTONS-1:0] r_sync2;
    logic [N_BUTTONS-1:0] w_sample;

    // Reset loads the released pin value so no spurious edge is seen on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= c_RELEASED_PINS;
            r_sync2 <= c_RELEASED_PINS;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2 ^ c_RELEASED_PINS;

    generate
        for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
            logic             w_s;
            logic             w_differs;
            logic             w_terminal;
            logic [CNT_W-1:0] r_cnt;
            logic             r_lvl;
            logic             r_prs;
            logic             r_rel;

            assign w_s        = w_sample[i];
            assign w_differs  = (w_s != r_lvl);
            assign w_terminal = (r_cnt == c_CNT_LAST);

            // Any sample agreeing with the accepted level restarts the count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                    r_prs <= 1'b0;
                    r_rel <= 1'b0;
                end else begin
                    r_prs <= 1'b0;
                    r_rel <= 1'b0;
                    if (!w_differs) begin
                        r_cnt <= '0;
                    end else if (w_terminal) begin
                        r_cnt <= '0;
                        r_lvl <= w_s;
                        r_prs <= w_s;
                        r_rel <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign btn_level[i]   = r_lvl;
            assign btn_press[i]   = r_prs;
            assign btn_release[i] = r_rel;

`ifdef AUTOREPEAT_EN
            localparam int HC_W = (REPEAT_DELAY  > 1) ? $clog2(REPEAT_DELAY)  : 1;
            localparam int PC_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
            localparam logic [HC_W-1:0] c_HC_LAST = HC_W'(REPEAT_DELAY - 1);
            localparam logic [PC_W-1:0] c_PC_LAST = PC_W'(REPEAT_PERIOD - 1);

            logic            w_press_evt;
            logic            w_release_evt;
            logic [HC_W-1:0] r_hc;
            logic [PC_W-1:0] r_pc;
            logic            r_periodic;
            logic            r_rpt;

            assign w_press_evt   = w_differs & w_terminal & w_s;
            assign w_release_evt = w_differs & w_terminal & ~w_s;

            // Initial delay runs on r_hc, then r_pc paces the periodic pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hc       <= '0;
                    r_pc       <= '0;
                    r_periodic <= 1'b0;
                    r_rpt      <= 1'b0;
                end else begin
                    r_rpt <= 1'b0;
                    if (!r_lvl || w_press_evt || w_release_evt) begin
                        r_hc       <= '0;
                        r_pc       <= '0;
                        r_periodic <= 1'b0;
                    end else if (!r_periodic) begin
                        if (r_hc == c_HC_LAST) begin
                            r_rpt      <= 1'b1;
                            r_periodic <= 1'b1;
                            r_pc       <= '0;
                        end else begin
                            r_hc <= r_hc + 1'b1;
                        end
                    end else begin
                        if (r_pc == c_PC_LAST) begin
                            r_rpt <= 1'b1;
                            r_pc  <= '0;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
            end

            assign btn_repeat[i] = r_rpt;
`endif
        end
    endgenerate

`ifndef AUTOREPEAT_EN
    assign btn_repeat = '0;
`endif

endmodule

`default_nettype wire
